epp_ram_port: RTL

EPP slave front end that gives the host PC byte-wide access to the on-chip dual-port RAM through the parallel port. Decodes Digilent-style EPP address/data cycles, exposes a pointer register and an auto-incrementing data register, and drives the RAM's host-side port. It sits directly upstream of the RAM block whose other port feeds `dataOutA`/`dataOutB`.

---
 rtl/epp_ram_port_if.sv | 20 ++
 rtl/epp_ram_port.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/epp_ram_port_if.sv
// EPP parallel-port bus as seen by the FPGA: host strobes and data in, FPGA data, enable and wait out.
interface epp_ram_port_if;
    logic       epp_astb_n;
    logic       epp_dstb_n;
    logic       epp_wr_n;
    logic [7:0] epp_db_in;
    logic [7:0] epp_db_out;
    logic       epp_db_oe;
    logic       epp_wait;

    modport master (
        output epp_astb_n, epp_dstb_n, epp_wr_n, epp_db_in,
        input  epp_db_out, epp_db_oe, epp_wait
    );

    modport slave (
        input  epp_astb_n, epp_dstb_n, epp_wr_n, epp_db_in,
        output epp_db_out, epp_db_oe, epp_wait
    );
endinterface

// File: rtl/epp_ram_port.sv
// EPP slave exposing a pointer register (0x00) and a RAM data register (0x01) on the RAM host port.
// Build macro EPP_RAM_AUTOINC_EN: pointer post-increments after each RAM data cycle.
module epp_ram_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    epp_ram_port_if.slave     epp,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);
    // IDLE wait for strobe | AWR/ARD address reg access | DWR data write | DRD1/DRD2 RAM latency, drive bus | HOLD wait release
    typedef enum logic [2:0] {IDLE, AWR, ARD, DWR, DRD1, DRD2, HOLD} stateT;

    stateT             state;
    stateT             stateNext;
    logic [1:0]        rstPipe;
    logic              rstSyncN;
    logic [1:0]        astbPipe;
    logic [1:0]        dstbPipe;
    logic [1:0]        wrPipe;
    logic              astb_s;
    logic              dstb_s;
    logic              wr_n_s;
    logic [7:0]        areg;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        readVal;
    logic [7:0]        dbOut;
    logic              dbOe;
    logic              eppWait;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstPipe <= 2'b00;
        else        rstPipe <= {rstPipe[0], 1'b1};
    end
    assign rstSyncN = rstPipe[1];

    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            astbPipe <= 2'b11;
            dstbPipe <= 2'b11;
            wrPipe   <= 2'b11;
        end else begin
            astbPipe <= {astbPipe[0], epp.epp_astb_n};
            dstbPipe <= {dstbPipe[0], epp.epp_dstb_n};
            wrPipe   <= {wrPipe[0], epp.epp_wr_n};
        end
    end
    assign astb_s = astbPipe[1];
    assign dstb_s = dstbPipe[1];
    assign wr_n_s = wrPipe[1];

    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) state <= IDLE;
        else           state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (!astb_s)      stateNext = wr_n_s ? ARD : AWR;
                else if (!dstb_s) stateNext = wr_n_s ? DRD1 : DWR;
            end
            AWR, ARD, DWR, DRD2: stateNext = HOLD;
            DRD1:                stateNext = DRD2;
            HOLD: if (astb_s && dstb_s) stateNext = IDLE;
            default:             stateNext = IDLE;
        endcase
    end

    always_comb begin
        readVal = 8'h00;
        if (areg == 8'h01)      readVal = ram_dout;
        else if (areg == 8'h00) readVal = 8'(ptr);
    end

`ifdef EPP_RAM_AUTOINC_EN
    logic dataCyc;

    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN)          dataCyc <= 1'b0;
        else if (state == IDLE) dataCyc <= (stateNext == DWR) || (stateNext == DRD1);
    end
`endif

    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            areg    <= 8'h00;
            ptr     <= '0;
            eppWait <= 1'b0;
            dbOe    <= 1'b0;
            dbOut   <= 8'h00;
            ram_we  <= 1'b0;
            ram_din <= 8'h00;
        end else begin
            ram_we <= 1'b0;
            // Write strobe is launched on entry to DWR so it is high for exactly the DWR cycle.
            if (state == IDLE && stateNext == DWR && areg == 8'h01) begin
                ram_we  <= 1'b1;
                ram_din <= epp.epp_db_in;
            end
            unique case (state)
                AWR: begin
                    areg    <= epp.epp_db_in;
                    eppWait <= 1'b1;
                end
                ARD: begin
                    dbOut   <= areg;
                    dbOe    <= 1'b1;
                    eppWait <= 1'b1;
                end
                DWR: begin
                    if (areg == 8'h00) ptr <= epp.epp_db_in[ADDR_W-1:0];
                    eppWait <= 1'b1;
                end
                DRD2: begin
                    dbOut   <= readVal;
                    dbOe    <= 1'b1;
                    eppWait <= 1'b1;
                end
                HOLD: begin
                    if (stateNext == IDLE) begin
                        eppWait <= 1'b0;
                        dbOe    <= 1'b0;
`ifdef EPP_RAM_AUTOINC_EN
                        if (dataCyc && areg == 8'h01) ptr <= ptr + ADDR_W'(1);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr       = ptr;
    assign epp.epp_db_out = dbOut;
    assign epp.epp_db_oe  = dbOe;
    assign epp.epp_wait   = eppWait;
endmodule
